// File: rtl/node_injector_if.sv
// Injection-point bundle: local request port, ring-forwarded port and the
// registered output toward the routing controller.
interface node_injector_if #(
   parameter int NODE_IP_BITWIDTH = 3
);
   localparam int PAY_W = 32 - 2*NODE_IP_BITWIDTH - 4;

   logic                        req_valid;
   logic                        req_ready;
   logic [NODE_IP_BITWIDTH-1:0] req_dest;
   logic [PAY_W-1:0]            req_payload;

   logic                        fwd_valid;
   logic [1:0]                  fwd_port;
   logic [31:0]                 fwd_instruction;
   logic                        fwd_ready;

   logic [31:0]                 instruction_out;
   logic [1:0]                  source_port;
   logic                        out_valid;
   logic                        out_ready;
   logic                        controller_enable;
   logic                        err_drop;

   modport master (
      output req_valid, req_dest, req_payload,
      output fwd_valid, fwd_port, fwd_instruction,
      output out_ready,
      input  req_ready, fwd_ready,
      input  instruction_out, source_port, out_valid, controller_enable, err_drop
   );

   modport slave (
      input  req_valid, req_dest, req_payload,
      input  fwd_valid, fwd_port, fwd_instruction,
      input  out_ready,
      output req_ready, fwd_ready,
      output instruction_out, source_port, out_valid, controller_enable, err_drop
   );
endinterface

// File: rtl/node_injector.sv
// Ring node injector: merges formatted local requests (via a small FIFO) with
// forwarded ring traffic into one registered output, with anti-starvation.
module node_injector #(
   parameter int                          NODE_IP_BITWIDTH = 3,
   parameter logic [NODE_IP_BITWIDTH-1:0] NODE_IP          = '0,
   parameter int                          FIFO_DEPTH       = 4,
   parameter int                          STARVE_LIMIT     = 3
) (
   input logic            clk,
   input logic            rst_n,
   node_injector_if.slave bus
);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [PW:0]   FULL_CNT   = (PW+1)'(FIFO_DEPTH);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   logic [31:0]   mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   count;
   logic [3:0]    seq;
   logic [SW-1:0] starve_cnt;

   logic fifo_empty, fifo_full, push, pop;
   logic load_slot, fwd_win, loc_win, fwd_legal;
   logic [31:0] local_word;

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == FULL_CNT);
   assign push       = bus.req_valid && !fifo_full;

   assign load_slot = !bus.out_valid || bus.out_ready;
   // Forwarded traffic has priority until local traffic has waited STARVE_LIMIT grants.
   assign fwd_win   = load_slot && bus.fwd_valid && (fifo_empty || (starve_cnt < STARVE_MAX));
   assign loc_win   = load_slot && !fwd_win && !fifo_empty;
   assign pop       = loc_win;
   assign fwd_legal = !bus.fwd_port[1];

   assign local_word = {bus.req_dest, NODE_IP, seq, bus.req_payload};

   assign bus.req_ready         = !fifo_full;
   assign bus.fwd_ready         = fwd_win;
   assign bus.controller_enable = bus.out_valid && bus.out_ready;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= local_word;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         seq    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            seq    <= seq + 4'd1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (fifo_empty || loc_win) begin
         starve_cnt <= '0;
      end else if (fwd_win && fwd_legal && (starve_cnt != STARVE_MAX)) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.instruction_out <= 32'h0;
         bus.source_port     <= 2'b00;
         bus.out_valid       <= 1'b0;
         bus.err_drop        <= 1'b0;
      end else begin
         bus.err_drop <= fwd_win && !fwd_legal;
         if (fwd_win && fwd_legal) begin
            bus.instruction_out <= bus.fwd_instruction;
            bus.source_port     <= bus.fwd_port;
            bus.out_valid       <= 1'b1;
         end else if (loc_win) begin
            bus.instruction_out <= mem[rd_ptr];
            bus.source_port     <= 2'b10;
            bus.out_valid       <= 1'b1;
         end else if (bus.out_ready) begin
            // A dropped illegal packet also lands here: the held word was consumed.
            bus.out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_node_injector.sv
// Directed bench for node_injector: hand-computed vectors checked with
// immediate assertions; prints a single pass/total summary.
module tb_node_injector;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   node_injector_if #(.NODE_IP_BITWIDTH(3)) bus ();

   node_injector #(
      .NODE_IP_BITWIDTH(3),
      .NODE_IP(3'b000),
      .FIFO_DEPTH(4),
      .STARVE_LIMIT(3)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.req_valid       = 1'b0;
      bus.req_dest        = 3'b000;
      bus.req_payload     = 22'h0;
      bus.fwd_valid       = 1'b0;
      bus.fwd_port        = 2'b00;
      bus.fwd_instruction = 32'h0;
      bus.out_ready       = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   logic [31:0] exp_b [4] = '{32'h4000_0010, 32'h4040_0011, 32'h4080_0012, 32'h40C0_0013};
   logic [1:0]  exp_sp[6] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00};
   logic        exp_fr[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
   logic [31:0] exp_c [6] = '{32'hF000_0000, 32'hF000_0001, 32'hF000_0002,
                              32'hF000_0003, 32'h2100_002A, 32'hF000_0005};

   initial begin
      // Reset state
      do_reset();
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_instr", bus.instruction_out, 32'h0);
      chk("rst_srcport", 32'(bus.source_port), 32'd0);
      chk("rst_err_drop", 32'(bus.err_drop), 32'd0);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_fwd_ready", 32'(bus.fwd_ready), 32'd0);

      // Single local request, two-cycle latency
      bus.out_ready   = 1'b1;
      bus.req_valid   = 1'b1;
      bus.req_dest    = 3'b101;
      bus.req_payload = 22'h1;
      tick();
      bus.req_valid = 1'b0;
      #1;
      chk("a_not_yet_valid", 32'(bus.out_valid), 32'd0);
      tick();
      chk("a_instr", bus.instruction_out, 32'hA000_0001);
      chk("a_srcport", 32'(bus.source_port), 32'd2);
      chk("a_ctrl_en", 32'(bus.controller_enable), 32'd1);
      tick();
      chk("a_cleared", 32'(bus.out_valid), 32'd0);

      // Stall output with a forwarded word, then fill the FIFO
      do_reset();
      bus.fwd_valid       = 1'b1;
      bus.fwd_port        = 2'b01;
      bus.fwd_instruction = 32'hDEAD_BEEF;
      #1;
      chk("b_fwd_ready", 32'(bus.fwd_ready), 32'd1);
      tick();
      bus.fwd_valid = 1'b0;
      chk("b_fwd_instr", bus.instruction_out, 32'hDEAD_BEEF);
      chk("b_fwd_port", 32'(bus.source_port), 32'd1);
      bus.req_valid = 1'b1;
      bus.req_dest  = 3'b010;
      for (int i = 0; i < 4; i++) begin
         bus.req_payload = 22'h10 + 22'(i);
         tick();
      end
      bus.fwd_valid = 1'b1;
      #1;
      chk("b_full_req_ready", 32'(bus.req_ready), 32'd0);
      chk("b_stall_fwd_ready", 32'(bus.fwd_ready), 32'd0);
      chk("b_stall_hold", bus.instruction_out, 32'hDEAD_BEEF);
      bus.fwd_valid = 1'b0;
      bus.out_ready = 1'b1;
      bus.req_payload = 22'h3F;
      #1;
      chk("b_no_bypass", 32'(bus.req_ready), 32'd0);
      tick();
      bus.req_valid = 1'b0;
      chk("b_order_0", bus.instruction_out, exp_b[0]);
      for (int i = 1; i < 4; i++) begin
         tick();
         chk($sformatf("b_order_%0d", i), bus.instruction_out, exp_b[i]);
      end
      tick();
      chk("b_drained", 32'(bus.out_valid), 32'd0);

      // Starvation limit: 3 forwarded grants with local pending, then local
      bus.req_valid   = 1'b1;
      bus.req_dest    = 3'b001;
      bus.req_payload = 22'h2A;
      bus.fwd_valid   = 1'b1;
      bus.fwd_port    = 2'b00;
      for (int k = 0; k < 6; k++) begin
         bus.fwd_instruction = 32'hF000_0000 + 32'(k);
         #1;
         chk($sformatf("c_fwd_ready_%0d", k), 32'(bus.fwd_ready), 32'(exp_fr[k]));
         tick();
         if (k == 0) bus.req_valid = 1'b0;
         chk($sformatf("c_srcport_%0d", k), 32'(bus.source_port), 32'(exp_sp[k]));
         chk($sformatf("c_instr_%0d", k), bus.instruction_out, exp_c[k]);
      end
      bus.fwd_valid = 1'b0;
      tick();
      chk("c_idle", 32'(bus.out_valid), 32'd0);

      // Illegal forwarded port is dropped
      bus.out_ready       = 1'b0;
      bus.fwd_valid       = 1'b1;
      bus.fwd_port        = 2'b11;
      bus.fwd_instruction = 32'h5555_5555;
      #1;
      chk("d_fwd_ready", 32'(bus.fwd_ready), 32'd1);
      tick();
      bus.fwd_valid = 1'b0;
      chk("d_err_pulse", 32'(bus.err_drop), 32'd1);
      chk("d_out_valid", 32'(bus.out_valid), 32'd0);
      tick();
      chk("d_err_single", 32'(bus.err_drop), 32'd0);
      chk("d_out_valid2", 32'(bus.out_valid), 32'd0);

      // Seq wrap over 17 pushes at full throughput
      do_reset();
      bus.out_ready = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_dest  = 3'b110;
      for (int i = 0; i < 17; i++) begin
         bus.req_payload = 22'(i);
         tick();
         if (i == 1) chk("e_word0", bus.instruction_out, 32'hC000_0000);
      end
      chk("e_word15", bus.instruction_out, 32'hC3C0_000F);
      bus.req_valid = 1'b0;
      tick();
      chk("e_word16_wrap", bus.instruction_out, 32'hC000_0010);
      chk("e_valid", 32'(bus.out_valid), 32'd1);

      // Async reset with packet in flight and two queued entries (dest == NODE_IP)
      do_reset();
      bus.req_valid = 1'b1;
      bus.req_dest  = 3'b000;
      for (int i = 0; i < 3; i++) begin
         bus.req_payload = 22'h7 + 22'(i);
         tick();
      end
      bus.req_valid = 1'b0;
      chk("f_self_dest", bus.instruction_out, 32'h0000_0007);
      chk("f_valid_before", 32'(bus.out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("f_rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("f_rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("f_rst_instr", bus.instruction_out, 32'h0);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("f_no_replay_%0d", i), 32'(bus.out_valid), 32'd0);
      end

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end
endmodule

// File: doc/node_injector.md
NODE_INJECTOR -- requirements
Module: node_injector

Interface
REQ-001 Parameter NODE_IP, default 3'b000: this node's ring address, inserted as the originating node.
REQ-002 Parameter NODE_IP_BITWIDTH, default 3: width of the destination and origin header fields.
REQ-003 Parameter FIFO_DEPTH, default 4: number of local-request FIFO entries (power of two).
REQ-004 Parameter STARVE_LIMIT, default 3: maximum consecutive forwarded grants while local traffic waits.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 req_valid  input  1  local packet request present.
REQ-008 req_ready  output  1  local request accepted this cycle when high with req_valid.
REQ-009 req_dest  input  3  destination node of the local request.
REQ-010 req_payload  input  22  local payload.
REQ-011 fwd_valid  input  1  ring-forwarded instruction present.
REQ-012 fwd_port  input  2  arrival port of the forwarded instruction; 2'b00 and 2'b01 are legal.
REQ-013 fwd_instruction  input  32  forwarded instruction word.
REQ-014 fwd_ready  output  1  forwarded instruction consumed this cycle.
REQ-015 instruction_out  output  32  registered instruction presented to the routing controller.
REQ-016 source_port  output  2  registered port tag: 2'b10 for local, fwd_port for forwarded.
REQ-017 out_valid  output  1  instruction_out and source_port hold a packet.
REQ-018 out_ready  input  1  downstream controller takes the packet this cycle.
REQ-019 controller_enable  output  1  combinational out_valid AND out_ready.
REQ-020 err_drop  output  1  one-cycle pulse when an illegal forwarded packet is discarded.

Function
REQ-021 Local word format SHALL be: [31:29] req_dest, [28:26] NODE_IP, [25:22] seq, [21:0] req_payload.
REQ-022 req_ready SHALL equal NOT fifo_full; when the FIFO is full, req_ready SHALL be low even if a pop occurs in the same cycle (no bypass).
REQ-023 A push (req_valid AND req_ready) SHALL store the formatted word and increment the 4-bit seq counter, which wraps 15 to 0.
REQ-024 Simultaneous push and pop on a non-full FIFO SHALL leave the occupancy unchanged; FIFO order SHALL be strictly first-in, first-out.
REQ-025 Load slot: a cycle in which out_valid is 0 or out_ready is 1.
REQ-026 Arbitration in a load slot: forwarded traffic wins if fwd_valid AND (FIFO empty OR starve_cnt < STARVE_LIMIT); otherwise the FIFO head wins if the FIFO is non-empty.
REQ-027 starve_cnt SHALL increment on a forwarded grant while the FIFO is non-empty, clear to 0 on a local grant or when the FIFO is empty, and saturate at STARVE_LIMIT.
REQ-028 Forwarded grant: fwd_ready=1; instruction_out <= fwd_instruction unmodified; source_port <= fwd_port; out_valid <= 1 on the next edge.
REQ-029 Local grant: pop the FIFO head; instruction_out <= head; source_port <= 2'b10; out_valid <= 1 on the next edge.
REQ-030 Illegal fwd_port (2'b10 or 2'b11) on a forwarded grant: fwd_ready=1 and the packet is discarded; err_drop SHALL pulse on the next cycle; the output register is not loaded; starve_cnt is unchanged.
REQ-031 A load slot with no grant and out_ready=1 SHALL clear out_valid.
REQ-032 While out_valid=1 and out_ready=0, instruction_out and source_port SHALL hold stable, and fwd_ready and FIFO pops SHALL be 0.
REQ-033 Latency: request to out_valid SHALL be a minimum of 2 cycles (push, then grant); forwarded to out_valid SHALL be 1 cycle; sustained throughput SHALL be one packet per cycle.
REQ-034 Local requests with req_dest == NODE_IP SHALL be injected unchanged; the downstream controller delivers them locally.

Reset
REQ-035 rst_n low SHALL immediately clear the FIFO (empty), seq, starve_cnt, out_valid, err_drop, instruction_out (32'h0) and source_port (2'b00), regardless of any packet in flight.
REQ-036 On reset release, req_ready SHALL be 1 in the first cycle and fwd_ready SHALL be 0 until a grant occurs.

Verification
REQ-037 Reset, then push dest=3'b101, payload=22'h1 with NODE_IP=0 and out_ready=1 -> 2 cycles later instruction_out=32'hA000_0001, source_port=2'b10, controller_enable=1.
REQ-038 Four pushes with out_ready=0 -> req_ready=0 after the 4th push; with out_ready then 1, outputs appear in order with seq 0,1,2,3.
REQ-039 fwd_valid held high continuously with one local request pending -> 3 forwarded grants, then 1 local grant, then forwarded grants resume.
REQ-040 fwd_port=2'b11 offered in a load slot -> fwd_ready=1, err_drop pulses once, out_valid unchanged.
REQ-041 17 local pushes -> seq in the 17th word = 4'h0 (wrap).
REQ-042 rst_n asserted low with out_valid=1 and the FIFO holding 2 entries -> out_valid=0 and req_ready=1 immediately; the old entries are never emitted.
